// File: rtl/mdv_multi_if.sv
// mdv_multi_if -- word-fetch bus between the microdrive replay engine and
// the memory holding the drive images.
//   mem_req  : word fetch request, held until mem_ack
//   mem_addr : 25-bit word address of the requested word
//   mem_ack  : one-cycle completion, mem_din valid in the same cycle
//   mem_din  : fetched 16-bit word
// master = replay engine, slave = memory side.
interface mdv_multi_if;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_din;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_din);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_din);
endinterface

// File: rtl/mdv_multi.sv
// mdv_multi -- multi-drive microdrive replay engine. Streams the records of
// the selected drive image (gap / header / gap / sector) out one bit per
// clock, fetching 16-bit words from memory one word ahead of the shifter.
//
// Ports:
//   mdv_clk   in   bit clock, one bit per rising edge
//   reset     in   asynchronous, active-high
//   sel       in   drive select, lowest set bit wins, all zero = motor off
//   len_we    in   load image length of drive len_idx
//   len_idx   in   drive index for len_we (>= DRIVES ignored)
//   len       in   image length in words
//   mem       if   word-fetch bus (mdv_multi_if.master)
//   gap       out  1 while off or in a gap (IRQ source)
//   rx_ready  out  byte strobe
//   dout      out  current byte
//   sector    out  sector counter
//   underrun  out  sticky fetch-late flag, cleared on restart
//
// Build option: define MDV_REVERSE_EN to replay records in descending
// order; otherwise records are replayed in ascending order with wrap.
module mdv_multi #(
  parameter int          DRIVES       = 2,
  parameter logic [24:0] BASE_ADDR    = 25'h800000,
  parameter logic [24:0] DRIVE_STRIDE = 25'h020000,
  parameter int          GAP_WORDS    = 35,
  parameter int          HDR_WORDS    = 14,
  parameter int          SEC_WORDS    = 329
) (
  input  logic              mdv_clk,
  input  logic              reset,
  input  logic [DRIVES-1:0] sel,
  input  logic              len_we,
  input  logic [2:0]        len_idx,
  input  logic [15:0]       len,
  mdv_multi_if.master       mem,
  output logic              gap,
  output logic              rx_ready,
  output logic [7:0]        dout,
  output logic [7:0]        sector,
  output logic              underrun
);

  localparam int REC = HDR_WORDS + SEC_WORDS;

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_GAP = 2'd1;
  localparam logic [1:0] ST_HDR = 2'd2;
  localparam logic [1:0] ST_SEC = 2'd3;

  // Image base address of every possible drive slot.
  logic [24:0] base_tab [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_base
      assign base_tab[gi] = BASE_ADDR + 25'(gi) * DRIVE_STRIDE;
    end
  endgenerate

  logic [15:0] len_reg [8];

  logic [1:0]  state_reg;
  logic [3:0]  bit_cnt_reg;
  logic [15:0] word_cnt_reg;
  logic        next_hdr_reg;
  logic [15:0] rec_off_reg;
  logic [24:0] addr_reg;
  logic        req_reg;
  logic [15:0] buf_reg;
  logic        buf_full_reg;
  logic [15:0] shift_reg;
  logic        valid_reg;
  logic [7:0]  sector_reg;
  logic        underrun_reg;
  logic [2:0]  run_idx_reg;
  logic [15:0] run_len_reg;

  // Active drive = lowest set select bit.
  logic [2:0] act_idx;
  logic       act_any;
  always_comb begin
    act_idx = 3'd0;
    act_any = 1'b0;
    for (int i = DRIVES - 1; i >= 0; i--) begin
      if (sel[i]) begin
        act_idx = 3'(i);
        act_any = 1'b1;
      end
    end
  end

  logic [15:0] act_len;
  logic [24:0] act_base;
  logic        present;
  assign act_len  = len_reg[act_idx];
  assign act_base = base_tab[act_idx];
  assign present  = act_any && (act_len >= 16'(REC));

  // The fetch address must stay inside the active image.
  logic [25:0] addr_ext, lo_ext, hi_ext;
  logic        out_of_range;
  assign addr_ext     = {1'b0, addr_reg};
  assign lo_ext       = {1'b0, act_base};
  assign hi_ext       = lo_ext + {10'd0, act_len};
  assign out_of_range = (addr_ext < lo_ext) || (addr_ext >= hi_ext);

  logic restart;
  assign restart = present && ((state_reg == ST_OFF) || (act_idx != run_idx_reg) ||
                               (act_len != run_len_reg) || out_of_range);

  logic        word_end, last_word, in_rec, idx_ok, fill_now, filled;
  logic [15:0] buf_eff;
  assign word_end = (bit_cnt_reg == 4'd15);
  assign in_rec   = (state_reg == ST_HDR) || (state_reg == ST_SEC);
  assign idx_ok   = (word_cnt_reg > 16'd5) &&
                    !((state_reg == ST_SEC) && (word_cnt_reg >= 16'd8) && (word_cnt_reg <= 16'd11));
  // An ack landing on the boundary cycle still counts as in time.
  assign fill_now = req_reg && mem.mem_ack;
  assign filled   = buf_full_reg || fill_now;
  assign buf_eff  = fill_now ? mem.mem_din : buf_reg;

  always_comb begin
    last_word = 1'b0;
    case (state_reg)
      ST_GAP:  last_word = (word_cnt_reg == 16'(GAP_WORDS - 1));
      ST_HDR:  last_word = (word_cnt_reg == 16'(HDR_WORDS - 1));
      ST_SEC:  last_word = (word_cnt_reg == 16'(SEC_WORDS - 1));
      default: last_word = 1'b0;
    endcase
  end

  // Offset of the record that follows the current one.
  logic [15:0] next_off;
`ifdef MDV_REVERSE_EN
  assign next_off = (rec_off_reg == 16'd0) ? (act_len - 16'(REC)) : (rec_off_reg - 16'(REC));
`else
  assign next_off = ((17'(rec_off_reg) + 17'(2 * REC)) > {1'b0, act_len}) ? 16'd0
                                                                          : (rec_off_reg + 16'(REC));
`endif

  always_ff @(posedge mdv_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) len_reg[i] <= 16'd0;
    end else if (len_we && (int'(len_idx) < DRIVES)) begin
      len_reg[len_idx] <= len;
    end
  end

  always_ff @(posedge mdv_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_OFF;
      bit_cnt_reg  <= 4'd0;
      word_cnt_reg <= 16'd0;
      next_hdr_reg <= 1'b1;
      rec_off_reg  <= 16'd0;
      addr_reg     <= BASE_ADDR;
      req_reg      <= 1'b0;
      buf_reg      <= 16'd0;
      buf_full_reg <= 1'b0;
      shift_reg    <= 16'd0;
      valid_reg    <= 1'b0;
      sector_reg   <= 8'd0;
      underrun_reg <= 1'b0;
      run_idx_reg  <= 3'd0;
      run_len_reg  <= 16'd0;
    end else if (restart) begin
      state_reg    <= ST_GAP;
      bit_cnt_reg  <= 4'd0;
      word_cnt_reg <= 16'd0;
      next_hdr_reg <= 1'b1;
      rec_off_reg  <= 16'd0;
      addr_reg     <= act_base;
      req_reg      <= 1'b0;
      buf_full_reg <= 1'b0;
      valid_reg    <= 1'b0;
      sector_reg   <= 8'd0;
      underrun_reg <= 1'b0;
      run_idx_reg  <= act_idx;
      run_len_reg  <= act_len;
    end else if (!present) begin
      state_reg    <= ST_OFF;
      bit_cnt_reg  <= 4'd0;
      req_reg      <= 1'b0;
      buf_full_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + 4'd1;
      if (fill_now) begin
        buf_reg      <= mem.mem_din;
        buf_full_reg <= 1'b1;
        req_reg      <= 1'b0;
      end
      if (word_end) begin
        valid_reg <= 1'b0;
        if (in_rec) begin
          shift_reg    <= buf_eff;
          buf_full_reg <= 1'b0;
          valid_reg    <= filled && idx_ok;
          if (!filled) underrun_reg <= 1'b1;
        end
        if (last_word) begin
          word_cnt_reg <= 16'd0;
          case (state_reg)
            ST_GAP: begin
              // First word of the header/sector is requested as the gap ends.
              state_reg    <= next_hdr_reg ? ST_HDR : ST_SEC;
              next_hdr_reg <= !next_hdr_reg;
              req_reg      <= 1'b1;
            end
            ST_HDR: begin
              state_reg <= ST_GAP;
              addr_reg  <= addr_reg + 25'd1;
              req_reg   <= 1'b0;
            end
            ST_SEC: begin
              state_reg   <= ST_GAP;
              sector_reg  <= sector_reg + 8'd1;
              rec_off_reg <= next_off;
              addr_reg    <= act_base + 25'(next_off);
              req_reg     <= 1'b0;
            end
            default: state_reg <= ST_OFF;
          endcase
        end else begin
          word_cnt_reg <= word_cnt_reg + 16'd1;
          if (in_rec) begin
            addr_reg <= addr_reg + 25'd1;
            req_reg  <= 1'b1;
          end
        end
      end
    end
  end

  assign mem.mem_req  = req_reg;
  assign mem.mem_addr = addr_reg;
  assign gap          = (state_reg == ST_OFF) || (state_reg == ST_GAP);
  assign dout         = bit_cnt_reg[3] ? shift_reg[7:0] : shift_reg[15:8];
  assign rx_ready     = present && valid_reg && (bit_cnt_reg[2:0] == 3'd2);
  assign sector       = sector_reg;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_mdv_multi.sv
// tb_mdv_multi -- directed bench for mdv_multi: reset state, gap length and
// first fetch, header/sector byte stream, record order and sector count,
// fetch underrun, drive switch restart, motor off and reset mid-fetch.
module tb_mdv_multi;

  logic        mdv_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = 2'b00;
  logic        len_we = 1'b0;
  logic [2:0]  len_idx = 3'd0;
  logic [15:0] len = 16'd0;
  logic        gap, rx_ready, underrun;
  logic [7:0]  dout, sector;

  int   checks = 0;
  int   failures = 0;
  logic hold = 1'b0;
  logic mon_on = 1'b0;

  logic [24:0] rec_addr_q[$];
  logic [7:0]  rec_sec_q[$];
  logic [7:0]  hdr_bytes[$];
  logic [7:0]  sec_bytes[$];
  logic [7:0]  exp_q[$];

  mdv_multi_if mem ();

  mdv_multi dut (
    .mdv_clk  (mdv_clk),
    .reset    (reset),
    .sel      (sel),
    .len_we   (len_we),
    .len_idx  (len_idx),
    .len      (len),
    .mem      (mem),
    .gap      (gap),
    .rx_ready (rx_ready),
    .dout     (dout),
    .sector   (sector),
    .underrun (underrun)
  );

  always #5 mdv_clk = ~mdv_clk;

  // Image contents seen by the memory model.
  function automatic logic [15:0] model(input logic [24:0] a);
    return (a == 25'h800006) ? 16'hFF12 : (a[15:0] ^ 16'h5A3C);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s got=%0h", tag, got);
    end
  endtask

  // Memory responder: acks two samples after seeing a request unless held.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem.mem_ack = 1'b0;
    mem.mem_din = 16'd0;
    forever begin
      @(negedge mdv_clk);
      if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
      end else if (mem.mem_req && !hold) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          mem.mem_ack = 1'b1;
          mem.mem_din = model(mem.mem_addr);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: logs each header/sector start address and the byte stream.
  initial begin
    logic prev_req, prev_gap;
    prev_req = 1'b0;
    prev_gap = 1'b1;
    forever begin
      @(negedge mdv_clk);
      if (mon_on) begin
        if (mem.mem_req && !prev_req && prev_gap) begin
          rec_addr_q.push_back(mem.mem_addr);
          rec_sec_q.push_back(sector);
        end
        if (rx_ready) begin
          if (rec_addr_q.size() == 1) hdr_bytes.push_back(dout);
          else if (rec_addr_q.size() == 2) sec_bytes.push_back(dout);
        end
      end
      prev_req = mem.mem_req;
      prev_gap = gap;
    end
  end

  initial begin
    int cyc, gap_cyc, err, rx_cnt, n;
    logic [15:0] w;
    logic seen;

    repeat (3) @(negedge mdv_clk);
    check("rst_gap", 32'(gap), 32'd1);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mem_req", 32'(mem.mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem.mem_addr), 32'h800000);
    check("rst_sector", 32'(sector), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);

    reset = 1'b0;
    @(negedge mdv_clk);
    len_we = 1'b1; len_idx = 3'd1; len = 16'd343;
    @(negedge mdv_clk);
    len_idx = 3'd0; len = 16'd686;
    @(negedge mdv_clk);
    len_we = 1'b0;
    mon_on = 1'b1;
    sel = 2'b01;

    // Gap of 35 words before the first header fetch.
    cyc = 0; gap_cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge mdv_clk);
      if (mem.mem_req) break;
      cyc++;
      if (gap) gap_cyc++;
    end
    check("gap_cycles", 32'(cyc), 32'd560);
    check("gap_high_cycles", 32'(gap_cyc), 32'd560);
    check("first_fetch_addr", 32'(mem.mem_addr), 32'h800000);
    check("gap_low_in_hdr", 32'(gap), 32'd0);
    check("underrun_clean", 32'(underrun), 32'd0);

    for (int i = 0; i < 20000; i++) begin
      if (rec_addr_q.size() >= 5) break;
      @(negedge mdv_clk);
    end
    check("rec_starts_seen", 32'(rec_addr_q.size() >= 5), 32'd1);

    // Header bytes: words 6..13 of record 0.
    exp_q.delete();
    for (int j = 6; j < 14; j++) begin
      w = model(25'h800000 + 25'(j));
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    check("hdr_byte_count", 32'(hdr_bytes.size()), 32'(exp_q.size()));
    check("hdr_byte0", 32'(hdr_bytes.size() > 0 ? hdr_bytes[0] : 8'h00), 32'hFF);
    check("hdr_byte1", 32'(hdr_bytes.size() > 1 ? hdr_bytes[1] : 8'h00), 32'h12);
    err = 0;
    n = (hdr_bytes.size() < exp_q.size()) ? hdr_bytes.size() : exp_q.size();
    for (int k = 0; k < n; k++) if (hdr_bytes[k] !== exp_q[k]) err++;
    check("hdr_byte_errors", 32'(err), 32'd0);

    // Sector bytes: words 6,7,12..328 of sector 0.
    exp_q.delete();
    for (int j = 0; j < 329; j++) begin
      if (j > 5 && !(j >= 8 && j <= 11)) begin
        w = model(25'h80000E + 25'(j));
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
    end
    check("sec_byte_count", 32'(sec_bytes.size()), 32'd638);
    err = 0;
    n = (sec_bytes.size() < exp_q.size()) ? sec_bytes.size() : exp_q.size();
    for (int k = 0; k < n; k++) if (sec_bytes[k] !== exp_q[k]) err++;
    check("sec_byte_errors", 32'(err), 32'd0);

    check("rec0_hdr_addr", 32'(rec_addr_q[0]), 32'h800000);
    check("rec0_sec_addr", 32'(rec_addr_q[1]), 32'h80000E);
    check("rec1_hdr_addr", 32'(rec_addr_q[2]), 32'h800157);
    check("rec1_sec_addr", 32'(rec_addr_q[3]), 32'h800165);
    check("rec2_hdr_addr", 32'(rec_addr_q[4]), 32'h800000);
    check("rec0_sector", 32'(rec_sec_q[0]), 32'd0);
    check("rec1_sector", 32'(rec_sec_q[2]), 32'd1);
    check("rec2_sector", 32'(rec_sec_q[4]), 32'd2);
    check("underrun_before_hold", 32'(underrun), 32'd0);

    // Withhold the fetch issued for header word 9 of record 2.
    repeat (136) @(negedge mdv_clk);
    hold = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (underrun) break;
      @(negedge mdv_clk);
    end
    check("underrun_set", 32'(underrun), 32'd1);
    rx_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (rx_ready) rx_cnt++;
      @(negedge mdv_clk);
    end
    check("rx_in_late_word", 32'(rx_cnt), 32'd0);
    hold = 1'b0;
    rx_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      if (rx_ready) rx_cnt++;
      @(negedge mdv_clk);
    end
    check("rx_resumes", 32'(rx_cnt > 0), 32'd1);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Switch to drive 1 in the middle of a sector.
    for (int i = 0; i < 2000; i++) begin
      if (rec_addr_q.size() >= 6) break;
      @(negedge mdv_clk);
    end
    check("in_sector", 32'(gap), 32'd0);
    repeat (100) @(negedge mdv_clk);
    sel = 2'b10;
    @(negedge mdv_clk);
    check("sw_gap", 32'(gap), 32'd1);
    check("sw_mem_addr", 32'(mem.mem_addr), 32'h820000);
    check("sw_sector", 32'(sector), 32'd0);
    check("sw_underrun", 32'(underrun), 32'd0);
    check("sw_mem_req", 32'(mem.mem_req), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge mdv_clk);
      if (mem.mem_req) begin seen = 1'b1; break; end
    end
    check("drv1_fetch_seen", 32'(seen), 32'd1);
    check("drv1_fetch_addr", 32'(mem.mem_addr), 32'h820000);

    // Motor off.
    sel = 2'b00;
    @(negedge mdv_clk);
    check("off_gap", 32'(gap), 32'd1);
    check("off_mem_req", 32'(mem.mem_req), 32'd0);
    check("off_rx_ready", 32'(rx_ready), 32'd0);

    // Reset while a fetch is outstanding.
    sel = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge mdv_clk);
      if (mem.mem_req) begin seen = 1'b1; break; end
    end
    check("drv0_fetch_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    check("midfetch_req_drop", 32'(mem.mem_req), 32'd0);
    check("midfetch_gap", 32'(gap), 32'd1);
    repeat (2) @(negedge mdv_clk);
    reset = 1'b0;
    repeat (40) @(negedge mdv_clk);
    check("post_rst_gap", 32'(gap), 32'd1);
    check("post_rst_req", 32'(mem.mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdv_multi.md
MDV_MULTI -- requirements
Module: mdv_multi

Interface
REQ-001 SHALL have parameter DRIVES, default 2, number of drives (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 25'h800000, word address of the drive 0 image.
REQ-003 SHALL have parameter DRIVE_STRIDE, default 25'h020000, word offset between drive images.
REQ-004 SHALL have parameter GAP_WORDS, default 35, gap length in words.
REQ-005 SHALL have parameters HDR_WORDS, default 14, and SEC_WORDS, default 329; record length REC = HDR_WORDS+SEC_WORDS.
REQ-006 SHALL have ports (clock and reset first):
- mdv_clk  in  1  bit clock, one bit per rising edge
- reset  in  1  asynchronous, active-high
- sel  in  DRIVES  drive select; lowest set bit wins; all zero = motor off
- len_we  in  1  load image length
- len_idx  in  3  drive index for len_we
- len  in  16  image length in words
- mem_req  out  1  word fetch request
- mem_addr  out  25  fetch word address
- mem_ack  in  1  one-cycle fetch completion, mem_din valid
- mem_din  in  16  fetched word
- gap  out  1  gap indication / IRQ source
- rx_ready  out  1  byte strobe
- dout  out  8  current byte
- sector  out  8  sector counter
- underrun  out  1  sticky fetch-late flag

Function
REQ-007 SHALL store one len per drive on len_we; idx >= DRIVES ignored; drive present when len >= REC.
REQ-008 SHALL have active drive d = lowest set bit of sel; base(d) = BASE_ADDR + d*DRIVE_STRIDE.
REQ-009 SHALL use FSM states OFF, GAP, HDR, SEC.
- OFF: no active present drive.
- GAP lasts GAP_WORDS words, then goes to HDR or SEC, alternating per the toggle bit.
- HDR lasts HDR_WORDS words, then GAP.
- SEC lasts SEC_WORDS words, then GAP.
REQ-010 SHALL count bits with a 4-bit bit_cnt; a word boundary is bit_cnt==15; FSM and word counters advance only at word boundaries.
REQ-011 SHALL restart on any change of the active drive or its len, and on leaving OFF.
- Restart values: state GAP, toggle = next-is-HDR, word count 0, mem_addr = base(d), sector 0.
- The restart takes effect on the next mdv_clk edge.
REQ-012 SHALL drive gap = 1 in OFF and in GAP, else 0.
REQ-013 SHALL at each word boundary load the shift word from the prefetch buffer.
- In HDR/SEC: increment mem_addr and assert mem_req for the next word.
- mem_req holds until mem_ack; on mem_ack the buffer captures mem_din and mem_req drops the same edge.
REQ-014 SHALL handle a missing fetch: if the buffer is not filled by the next word boundary, set underrun (sticky until restart) and force data_valid 0 for that word.
REQ-015 SHALL register data_valid at the word boundary as 1 only when all of:
- state HDR or SEC;
- record word index > 5;
- not (SEC and index 8..11).
REQ-016 SHALL output dout = bit_cnt[3] ? word[7:0] : word[15:8].
REQ-017 SHALL assert rx_ready = present && data_valid && bit_cnt[2:0]==2, one bit period per byte.
REQ-018 SHALL at the end of SEC increment sector (8-bit wrap) and set the next record start.
REQ-019 SHALL bound addresses: any mem_addr outside base(d)..base(d)+len-1 forces a restart.

Reset
REQ-020 SHALL on reset set:
- state OFF, bit_cnt 0, mem_req 0, mem_addr BASE_ADDR;
- all len 0, sector 0, underrun 0, data_valid 0, dout 0;
- gap 1, rx_ready 0.
REQ-021 SHALL, when reset is asserted mid-fetch, drop mem_req immediately and ignore any late mem_ack.

Configuration
REQ-022 SHALL support macro MDV_REVERSE_EN, which selects the record replay order.
- Defined: replay records in descending order; the record after the one at base(d) is the one at base(d)+len-REC, otherwise start-REC.
- Undefined: replay in ascending order; start+REC, wrapping to base(d) when start+2*REC > len.

Verification
REQ-023 Reset, then len_we idx0 len=686, sel=01 -> gap=1 for 35 words, then mem_req with mem_addr=800000.
REQ-024 Drive 0, header word 6 = 16'hFF12 -> rx_ready pulses, dout=FF then 12; no rx_ready during header words 0..5 or sector words 8..11.
REQ-025 len=686, MDV_REVERSE_EN defined -> second record fetched from 800157; undefined -> 800157 then wrap to 800000; sector increments 0,1,2.
REQ-026 sel 01->10 mid-sector, drive 1 len=343 -> restart: gap=1, mem_addr=820000, sector=0, underrun=0.
REQ-027 Withhold mem_ack for 16 bits -> underrun=1, no rx_ready that word; sel=00 -> state OFF, gap=1.
